// File: rtl/hsi_mse_lanes.sv
// rtl/hsi_mse_lanes.sv - multi-lane HSI mean-square-error engine with vector framing checks (optional saturation: HSI_MSE_LANES_SAT_EN)
module hsi_mse_lanes #(
    parameter int WORD_WIDTH       = 32,
    parameter int DATA_WIDTH       = 16,
    parameter int DATA_WIDTH_MUL   = 32,
    parameter int DATA_WIDTH_ACC   = 48,
    parameter int HSI_BANDS        = 128,
    parameter int HSI_LIBRARY_SIZE = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                element_valid,
    input  logic                                element_start,
    input  logic                                element_last,
    input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] vctr_ref,
    input  logic [WORD_WIDTH-1:0]               element_a,
    input  logic [WORD_WIDTH-1:0]               element_b,
    output logic [WORD_WIDTH-1:0]               mse_value,
    output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] mse_ref,
    output logic                                mse_error,
    output logic                                mse_valid
);

    localparam int CHANNELS              = WORD_WIDTH / DATA_WIDTH;
    localparam int WORDS_PER_VCTR        = HSI_BANDS / CHANNELS;
    localparam int HSI_BANDS_ADDR        = $clog2(HSI_BANDS);
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE);
    localparam int SUM_WIDTH             = DATA_WIDTH_ACC + $clog2(CHANNELS) + 1;
    localparam int CNT_WIDTH             = $clog2(WORDS_PER_VCTR + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(WORDS_PER_VCTR);

    // Per-word control travelling alongside the lane data through S0..S2
    typedef struct packed {
        logic                             valid;
        logic                             start;
        logic                             emit;
        logic                             err;
        logic [HSI_LIBRARY_SIZE_ADDR-1:0] rid;
    } ctl_t;

    // Result tag carried past the accumulators (S3, S4)
    typedef struct packed {
        logic                             emit;
        logic                             err;
        logic [HSI_LIBRARY_SIZE_ADDR-1:0] rid;
    } res_t;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                           state;
    logic [CNT_WIDTH-1:0]             cnt;
    logic [CNT_WIDTH-1:0]             cnt_inc;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] cur_ref;

    ctl_t                             s0_ctl;
    ctl_t                             s1_ctl;
    ctl_t                             s2_ctl;
    res_t                             s3_res;
    res_t                             s4_res;

    logic [WORD_WIDTH-1:0]            s0_a;
    logic [WORD_WIDTH-1:0]            s0_b;
    logic signed [DATA_WIDTH:0]       s1_diff [CHANNELS];
    logic [DATA_WIDTH_MUL-1:0]        s2_sq   [CHANNELS];
    logic [DATA_WIDTH_ACC-1:0]        acc     [CHANNELS];
    logic [SUM_WIDTH-1:0]             lane_sum;
    logic [SUM_WIDTH-1:0]             s4_sum;
    logic [SUM_WIDTH-1:0]             shifted;
    logic [WORD_WIDTH-1:0]            res_value;

    // Word counter advance, held at its ceiling so runaway vectors still flag an error
    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end

    // S0: framing FSM; registers the word and tags it with accumulate/emit/error/ref
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_ref <= '0;
            s0_ctl  <= '0;
            s0_a    <= '0;
            s0_b    <= '0;
        end else begin
            s0_a         <= element_a;
            s0_b         <= element_b;
            s0_ctl.valid <= 1'b0;
            s0_ctl.start <= 1'b0;
            s0_ctl.emit  <= 1'b0;
            s0_ctl.err   <= 1'b0;
            s0_ctl.rid   <= element_start ? vctr_ref : cur_ref;
            if (element_valid) begin
                if (element_start) begin
                    // A start always opens a fresh vector, abandoning any partial one
                    s0_ctl.valid <= 1'b1;
                    s0_ctl.start <= 1'b1;
                    cur_ref      <= vctr_ref;
                    cnt          <= CNT_ONE;
                    if (element_last) begin
                        s0_ctl.emit <= 1'b1;
                        s0_ctl.err  <= (CNT_ONE != CNT_FULL);
                        state       <= IDLE;
                    end else begin
                        state       <= ACC;
                    end
                end else if (state == ACC) begin
                    s0_ctl.valid <= 1'b1;
                    cnt          <= cnt_inc;
                    if (element_last) begin
                        s0_ctl.emit <= 1'b1;
                        s0_ctl.err  <= (cnt_inc != CNT_FULL);
                        state       <= IDLE;
                    end
                end
                // Words without a start while IDLE are orphans and are dropped
            end
        end
    end

    // S1: per-lane signed difference, one bit wider than a sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctl <= '0;
            for (int i = 0; i < CHANNELS; i++) s1_diff[i] <= '0;
        end else begin
            s1_ctl <= s0_ctl;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_diff[i] <= $signed({1'b0, s0_a[i*DATA_WIDTH +: DATA_WIDTH]})
                            - $signed({1'b0, s0_b[i*DATA_WIDTH +: DATA_WIDTH]});
            end
        end
    end

    // S2: per-lane square; result is non-negative so truncation to the multiplier width is exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_ctl <= '0;
            for (int i = 0; i < CHANNELS; i++) s2_sq[i] <= '0;
        end else begin
            s2_ctl <= s1_ctl;
            for (int i = 0; i < CHANNELS; i++) begin
                s2_sq[i] <= DATA_WIDTH_MUL'(s1_diff[i] * s1_diff[i]);
            end
        end
    end

    // S3: per-lane accumulate; a start word loads so back-to-back vectors need no clear cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_res <= '0;
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else begin
            s3_res.emit <= s2_ctl.emit;
            s3_res.err  <= s2_ctl.err;
            s3_res.rid  <= s2_ctl.rid;
            if (s2_ctl.valid) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc[i] <= s2_ctl.start ? DATA_WIDTH_ACC'(s2_sq[i])
                                           : acc[i] + DATA_WIDTH_ACC'(s2_sq[i]);
                end
            end
        end
    end

    // Lane sum, wide enough that adding all lanes never wraps
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lane_sum = lane_sum + SUM_WIDTH'(acc[i]);
        end
    end

    // S4: register the lane sum with its result tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s4_res <= '0;
            s4_sum <= '0;
        end else begin
            s4_res <= s3_res;
            s4_sum <= lane_sum;
        end
    end

    // Mean by power-of-two band count, then fit into the output word
    always_comb begin
        shifted = s4_sum >> HSI_BANDS_ADDR;
`ifdef HSI_MSE_LANES_SAT_EN
        res_value = (|shifted[SUM_WIDTH-1:WORD_WIDTH]) ? '1 : shifted[WORD_WIDTH-1:0];
`else
        res_value = shifted[WORD_WIDTH-1:0];
`endif
    end

`ifndef HSI_MSE_LANES_SAT_EN
    logic unused_shifted_hi;
    assign unused_shifted_hi = ^shifted[SUM_WIDTH-1:WORD_WIDTH];
`endif

    // Output stage: one-cycle strobe, result fields hold until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mse_value <= '0;
            mse_ref   <= '0;
            mse_error <= 1'b0;
            mse_valid <= 1'b0;
        end else begin
            mse_valid <= s4_res.emit;
            if (s4_res.emit) begin
                mse_value <= res_value;
                mse_ref   <= s4_res.rid;
                mse_error <= s4_res.err;
            end
        end
    end

endmodule

// File: tb/tb_hsi_mse_lanes.sv
// tb/tb_hsi_mse_lanes.sv - directed self-checking bench for hsi_mse_lanes
module tb_hsi_mse_lanes;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        v, s, l;
    logic [7:0]  ref_in;
    logic [31:0] a, b;
    logic [31:0] mse_value;
    logic [7:0]  mse_ref;
    logic        mse_error, mse_valid;

    logic        v1, s1, l1;
    logic [7:0]  ref1;
    logic [15:0] a1, b1;
    logic [15:0] val1;
    logic [7:0]  ref1_o;
    logic        err1, valid1;

    typedef struct {
        logic [31:0] v;
        logic [7:0]  r;
        logic        e;
        int          c;
    } res_t;

    res_t q[$];
    res_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hsi_mse_lanes #(
        .WORD_WIDTH(32), .DATA_WIDTH(16), .DATA_WIDTH_MUL(32),
        .DATA_WIDTH_ACC(48), .HSI_BANDS(8), .HSI_LIBRARY_SIZE(256)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .element_valid(v), .element_start(s), .element_last(l),
        .vctr_ref(ref_in), .element_a(a), .element_b(b),
        .mse_value(mse_value), .mse_ref(mse_ref),
        .mse_error(mse_error), .mse_valid(mse_valid)
    );

    hsi_mse_lanes #(
        .WORD_WIDTH(16), .DATA_WIDTH(16), .DATA_WIDTH_MUL(32),
        .DATA_WIDTH_ACC(48), .HSI_BANDS(2), .HSI_LIBRARY_SIZE(256)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .element_valid(v1), .element_start(s1), .element_last(l1),
        .vctr_ref(ref1), .element_a(a1), .element_b(b1),
        .mse_value(val1), .mse_ref(ref1_o),
        .mse_error(err1), .mse_valid(valid1)
    );

    always @(negedge clk) begin
        if (mse_valid === 1'b1) q.push_back('{mse_value, mse_ref, mse_error, cyc});
        if (valid1 === 1'b1) q1.push_back('{{16'h0, val1}, ref1_o, err1, cyc});
    end

    task automatic send(input logic st, input logic la, input logic [7:0] r,
                        input logic [15:0] av, input logic [15:0] bv);
        @(negedge clk);
        v = 1'b1; s = st; l = la; ref_in = r;
        a = {av, av}; b = {bv, bv};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            v = 1'b0; s = 1'b0; l = 1'b0;
        end
    endtask

    task automatic send_vec(input logic [7:0] r, input int n, input logic [15:0] av,
                            input logic [15:0] bv, output int last_edge);
        last_edge = 0;
        for (int i = 0; i < n; i++) begin
            send(i == 0, i == n - 1, r, av, bv);
            if (i == n - 1) last_edge = cyc + 1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++; if (mse_value !== 32'h0) begin errors++; $display("FAIL reset_value: got %0h expected 0", mse_value); end
        checks++; if (mse_ref !== 8'h0) begin errors++; $display("FAIL reset_ref: got %0h expected 0", mse_ref); end
        checks++; if (mse_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", mse_error); end
        checks++; if (mse_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", mse_valid); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_nominal;
        int le;
        q.delete();
        send_vec(8'd7, 4, 16'd5, 16'd2, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL nominal_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'd9) begin errors++; $display("FAIL nominal_value: got %0d expected 9", q[0].v); end
            checks++; if (q[0].r !== 8'd7) begin errors++; $display("FAIL nominal_ref: got %0d expected 7", q[0].r); end
            checks++; if (q[0].e !== 1'b0) begin errors++; $display("FAIL nominal_error: got %0b expected 0", q[0].e); end
            checks++; if (q[0].c !== le + 5) begin errors++; $display("FAIL nominal_latency: got edge %0d expected %0d", q[0].c, le + 5); end
        end
    endtask

    task automatic test_back_to_back;
        int le0, le1;
        q.delete();
        send_vec(8'd3, 4, 16'd10, 16'd6, le0);
        send_vec(8'd4, 4, 16'd9, 16'd9, le1);
        idle(12);
        checks++; if (q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", q.size()); end
        if (q.size() >= 2) begin
            checks++; if (q[0].v !== 32'd16) begin errors++; $display("FAIL b2b_value0: got %0d expected 16", q[0].v); end
            checks++; if (q[0].r !== 8'd3) begin errors++; $display("FAIL b2b_ref0: got %0d expected 3", q[0].r); end
            checks++; if (q[0].e !== 1'b0) begin errors++; $display("FAIL b2b_error0: got %0b expected 0", q[0].e); end
            checks++; if (q[1].v !== 32'd0) begin errors++; $display("FAIL b2b_value1: got %0d expected 0", q[1].v); end
            checks++; if (q[1].r !== 8'd4) begin errors++; $display("FAIL b2b_ref1: got %0d expected 4", q[1].r); end
            checks++; if (q[1].e !== 1'b0) begin errors++; $display("FAIL b2b_error1: got %0b expected 0", q[1].e); end
            checks++; if (q[0].c !== le0 + 5) begin errors++; $display("FAIL b2b_latency0: got edge %0d expected %0d", q[0].c, le0 + 5); end
            checks++; if (q[1].c !== le1 + 5) begin errors++; $display("FAIL b2b_latency1: got edge %0d expected %0d", q[1].c, le1 + 5); end
        end
    endtask

    task automatic test_short;
        int le;
        q.delete();
        send_vec(8'd1, 3, 16'd4, 16'd0, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL short_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'd12) begin errors++; $display("FAIL short_value: got %0d expected 12", q[0].v); end
            checks++; if (q[0].e !== 1'b1) begin errors++; $display("FAIL short_error: got %0b expected 1", q[0].e); end
            checks++; if (q[0].r !== 8'd1) begin errors++; $display("FAIL short_ref: got %0d expected 1", q[0].r); end
        end
    endtask

    task automatic test_restart;
        int le;
        q.delete();
        send(1'b1, 1'b0, 8'd2, 16'd100, 16'd0);
        send(1'b0, 1'b0, 8'd2, 16'd100, 16'd0);
        send(1'b0, 1'b0, 8'd2, 16'd100, 16'd0);
        send_vec(8'd9, 4, 16'd7, 16'd4, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL restart_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'd9) begin errors++; $display("FAIL restart_value: got %0d expected 9", q[0].v); end
            checks++; if (q[0].r !== 8'd9) begin errors++; $display("FAIL restart_ref: got %0d expected 9", q[0].r); end
            checks++; if (q[0].e !== 1'b0) begin errors++; $display("FAIL restart_error: got %0b expected 0", q[0].e); end
        end
    endtask

    task automatic test_orphan;
        int le;
        q.delete();
        send(1'b0, 1'b0, 8'd5, 16'd50, 16'd0);
        send(1'b0, 1'b0, 8'd5, 16'd50, 16'd0);
        send(1'b0, 1'b1, 8'd5, 16'd50, 16'd0);
        idle(10);
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL orphan_count: got %0d expected 0", q.size()); end
        q.delete();
        send_vec(8'd11, 4, 16'd6, 16'd1, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL orphan_next_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'd25) begin errors++; $display("FAIL orphan_next_value: got %0d expected 25", q[0].v); end
            checks++; if (q[0].r !== 8'd11) begin errors++; $display("FAIL orphan_next_ref: got %0d expected 11", q[0].r); end
        end
    endtask

    task automatic test_reset_mid;
        int le;
        q.delete();
        send(1'b1, 1'b0, 8'd12, 16'd200, 16'd0);
        send(1'b0, 1'b0, 8'd12, 16'd200, 16'd0);
        @(negedge clk);
        v = 1'b0; s = 1'b0; l = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mse_value !== 32'h0) begin errors++; $display("FAIL rstmid_value: got %0h expected 0", mse_value); end
        checks++; if (mse_ref !== 8'h0) begin errors++; $display("FAIL rstmid_ref: got %0h expected 0", mse_ref); end
        idle(2);
        rst_n = 1'b1;
        idle(10);
        checks++; if (q.size() !== 0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", q.size()); end
        q.delete();
        send_vec(8'd13, 4, 16'd3, 16'd1, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'd4) begin errors++; $display("FAIL rstmid_next_value: got %0d expected 4", q[0].v); end
            checks++; if (q[0].e !== 1'b0) begin errors++; $display("FAIL rstmid_next_error: got %0b expected 0", q[0].e); end
        end
    endtask

    task automatic test_saturation;
        int le;
        logic [15:0] exp1;
`ifdef HSI_MSE_LANES_SAT_EN
        exp1 = 16'hFFFF;
`else
        exp1 = 16'h0001;
`endif
        q.delete();
        q1.delete();
        send_vec(8'd20, 4, 16'hFFFF, 16'h0000, le);
        idle(10);
        checks++; if (q.size() !== 1) begin errors++; $display("FAIL sat32_count: got %0d expected 1", q.size()); end
        if (q.size() >= 1) begin
            checks++; if (q[0].v !== 32'hFFFE0001) begin errors++; $display("FAIL sat32_value: got %0h expected fffe0001", q[0].v); end
        end
        @(negedge clk);
        v1 = 1'b1; s1 = 1'b1; l1 = 1'b0; ref1 = 8'd21; a1 = 16'hFFFF; b1 = 16'h0000;
        @(negedge clk);
        s1 = 1'b0; l1 = 1'b1; ref1 = 8'd0;
        @(negedge clk);
        v1 = 1'b0; l1 = 1'b0;
        idle(10);
        checks++; if (q1.size() !== 1) begin errors++; $display("FAIL sat16_count: got %0d expected 1", q1.size()); end
        if (q1.size() >= 1) begin
            checks++; if (q1[0].v[15:0] !== exp1) begin errors++; $display("FAIL sat16_value: got %0h expected %0h", q1[0].v[15:0], exp1); end
            checks++; if (q1[0].r !== 8'd21) begin errors++; $display("FAIL sat16_ref: got %0d expected 21", q1[0].r); end
            checks++; if (q1[0].e !== 1'b0) begin errors++; $display("FAIL sat16_error: got %0b expected 0", q1[0].e); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v = 1'b0; s = 1'b0; l = 1'b0; ref_in = 8'h0; a = 32'h0; b = 32'h0;
        v1 = 1'b0; s1 = 1'b0; l1 = 1'b0; ref1 = 8'h0; a1 = 16'h0; b1 = 16'h0;
        test_reset();
        test_nominal();
        test_back_to_back();
        test_short();
        test_restart();
        test_orphan();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
